ahbl_slave_mem: RTL



---
 rtl/ahbl_slave_mem.sv | 102 ++++++++++
 1 files changed

// File: rtl/ahbl_slave_mem.sv
// ahbl_slave_mem: AHB-Lite slave RAM model with fixed wait states and a two-cycle ERROR response
// Ports: HCLK/HRESETN clock and async active-low reset; HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
// HREADYIN are the slave-side bus inputs (HBURST, HPROT, HMASTLOCK accepted but ignored);
// HREADYOUT, HRESP, HRDATA form the slave response.
module ahbl_slave_mem #(
  parameter int MEM_AWIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] mem [2**MEM_AWIDTH];
  logic p_valid, p_write;
  logic [MEM_AWIDTH-1:0] p_idx, a_idx;
  logic [3:0] p_be, a_be;
  logic acc, legal, commit;
  logic [31:0] mask, merged, rd_word;
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:MEM_AWIDTH+2]};
  assign a_idx = HADDR[MEM_AWIDTH+1:2];
  // Only IDLE and ERR2 have HREADYOUT high, so only they can see a new address phase.
  assign acc = HSEL & HTRANS[1] & HREADYIN & (state == S_IDLE || state == S_ERR2);
  assign legal = HSIZE == 3'd0 || (HSIZE == 3'd1 && !HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] == 2'b00);
  assign a_be = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // A pending write completes on the edge leaving an IDLE data-phase cycle.
  assign commit = state == S_IDLE && p_valid && p_write;
  assign mask = {{8{p_be[3]}}, {8{p_be[2]}}, {8{p_be[1]}}, {8{p_be[0]}}};
  assign merged = (HWDATA & mask) | (mem[p_idx] & ~mask);
  // A read landing on the word being written this edge sees the post-write value.
  assign rd_word = (commit && p_idx == a_idx) ? merged : mem[a_idx];
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    HREADYOUT = 1'b1;
    HRESP = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        HRESP = state == S_ERR2;
        if (acc && !legal) state_nx = S_ERR1;
        else if (acc && WS != 4'd0) begin
          state_nx = S_WAIT;
          cnt_nx = WS;
        end
        else state_nx = S_IDLE;
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = S_IDLE;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP = 1'b1;
        state_nx = S_ERR2;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      state <= S_IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      p_valid <= 1'b0;
      p_write <= 1'b0;
      p_idx <= '0;
      p_be <= 4'd0;
      HRDATA <= 32'd0;
    end else begin
      if (acc) begin
        p_valid <= legal;
        p_write <= HWRITE;
        p_idx <= a_idx;
        p_be <= a_be;
      end else if (state == S_IDLE) p_valid <= 1'b0;
      if (acc && legal && !HWRITE) HRDATA <= rd_word;
    end
  always_ff @(posedge HCLK)
    if (commit) mem[p_idx] <= merged;
endmodule
